mmio_hub: RTL

Parametrised successor of the game MMIO decoder, sitting between the processor load/store port and the per-player coprocessor set (physics, collision, attack, damage, controller).
- Supports N_PLAYERS channels.
- Physics/collision constants become software-writable config registers instead of hard-coded values.
- Coprocessor outputs are sampled once per frame into shadow registers, so reads within a frame are coherent.
- Sticky read-to-clear event flags record hits, landings and attacks.
- Reads are registered with a valid strobe.

---
 rtl/mmio_hub_pkg.sv | 49 ++++
 rtl/mmio_event_latch.sv | 47 ++++
 rtl/mmio_hub.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_hub_pkg.sv
// mmio_hub_pkg
// Shared definitions for the MMIO hub: the 32-bit bus word type, the
// coprocessor-space block ids, per-player config field ids, global config
// indices, event flag bit positions and the start-position helper.
// No ports (package).
package mmio_hub_pkg;

  typedef logic [31:0] word_t;

  // Block ids carried in address[11:7]
  localparam logic [4:0] BLK_POS    = 5'd0;
  localparam logic [4:0] BLK_CTRL   = 5'd1;
  localparam logic [4:0] BLK_COLL   = 5'd2;
  localparam logic [4:0] BLK_ATTACK = 5'd3;
  localparam logic [4:0] BLK_DAMAGE = 5'd4;
  localparam logic [4:0] BLK_EVENT  = 5'd5;
  localparam logic [4:0] BLK_PCFG   = 5'd8;
  localparam logic [4:0] BLK_GCFG   = 5'd9;
  localparam logic [4:0] BLK_FRAME  = 5'd10;

  // Per-player config field, low two bits of idx
  localparam logic [1:0] FLD_MASS  = 2'd0;
  localparam logic [1:0] FLD_START = 2'd1;
  localparam logic [1:0] FLD_SIZE  = 2'd2;

  // Global config indices
  localparam logic [4:0] GI_GRAVITY    = 5'd0;
  localparam logic [4:0] GI_WIND       = 5'd1;
  localparam logic [4:0] GI_STAGE_POS  = 5'd2;
  localparam logic [4:0] GI_STAGE_SIZE = 5'd3;
  localparam logic [4:0] GI_CONTROL    = 5'd4;

  // Event flag bit positions
  localparam int EV_HIT  = 0;
  localparam int EV_LAND = 1;
  localparam int EV_ATK  = 2;
  localparam int EV_BITS = 3;

  // Start position for player i: x advances by step per player, y is shared
  function automatic word_t start_pos_default(input logic [15:0] base,
                                              input logic [15:0] step,
                                              input logic [15:0] y,
                                              input int unsigned i);
    logic [15:0] x;
    x = base + 16'(i) * step;
    return {x, y};
  endfunction

endpackage

// File: rtl/mmio_event_latch.sv
// mmio_event_latch
// Sticky event flags for one player. On a snapshot update it compares the
// incoming coprocessor values with the current shadows and sets HIT, LAND
// and ATK; a read of the flag register clears them, but a set on the same
// edge wins.
// Ports:
//   clock, reset      system clock, synchronous active-low reset
//   snap              snapshot update strobe (shadows load this edge)
//   clr               flag register read this edge
//   dmg_new/dmg_old   incoming damage / current damage shadow
//   coll_new/coll_old incoming collision / current collision shadow
//   atk_new/atk_old   bit0 of incoming attack / of attack shadow
//   flags             sticky flags {ATK, LAND, HIT}
module mmio_event_latch
  import mmio_hub_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               snap,
  input  logic               clr,
  input  word_t              dmg_new,
  input  word_t              dmg_old,
  input  word_t              coll_new,
  input  word_t              coll_old,
  input  logic               atk_new,
  input  logic               atk_old,
  output logic [EV_BITS-1:0] flags
);

  logic [EV_BITS-1:0] set;

  always_comb begin
    set = '0;
    if (snap) begin
      set[EV_HIT]  = (dmg_new != dmg_old);
      set[EV_LAND] = (coll_old == '0) && (coll_new != '0);
      set[EV_ATK]  = atk_new & ~atk_old;
    end
  end

  // Clear is applied first so a simultaneous set survives
  always_ff @(posedge clock) begin
    if (!reset) flags <= '0;
    else        flags <= (clr ? '0 : flags) | set;
  end

endmodule

// File: rtl/mmio_hub.sv
// mmio_hub
// Load/store decoder between the processor and the per-player coprocessors.
// address[12]=0 goes to DMEM; address[12]=1 selects coprocessor space with
// blk = address[11:7], idx = address[6:2]. Holds frame-coherent shadows of
// the coprocessor outputs, sticky event flags, software config registers
// and a frame counter. Reads are registered with a one-cycle valid strobe.
// Ports:
//   clock, reset            system clock, synchronous active-low reset
//   address, data_in        word address and write data
//   wren, rden              write / read strobes
//   data_out, rd_valid      registered read data and its valid strobe
//   dmem_address/_wren/_q   DMEM pass-through (q valid same cycle)
//   frame_tick              one-cycle pulse per video frame
//   pos_in..damage_in       live coprocessor outputs, 32 bits per player
//   mass/start_pos/size_out per-player config, 32 bits per player
//   gravity/wind/stage_*    global config
module mmio_hub
  import mmio_hub_pkg::*;
#(
  parameter int unsigned N_PLAYERS      = 2,
  parameter logic [31:0] DEF_GRAVITY    = 32'h00010000,
  parameter logic [31:0] DEF_WIND       = 32'h00000010,
  parameter logic [31:0] DEF_MASS       = 32'h00000010,
  parameter logic [15:0] START_X_BASE   = 16'h0160,
  parameter logic [15:0] START_X_STEP   = 16'h0149,
  parameter logic [15:0] START_Y        = 16'h00FA,
  parameter logic [31:0] DEF_STAGE_POS  = 32'h01580014,
  parameter logic [31:0] DEF_STAGE_SIZE = 32'h01CC006E
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [12:0]             address,
  input  logic [31:0]             data_in,
  input  logic                    wren,
  input  logic                    rden,
  output logic [31:0]             data_out,
  output logic                    rd_valid,
  output logic [11:0]             dmem_address,
  output logic                    dmem_wren,
  input  logic [31:0]             dmem_q,
  input  logic                    frame_tick,
  input  logic [N_PLAYERS*32-1:0] pos_in,
  input  logic [N_PLAYERS*32-1:0] ctrl_in,
  input  logic [N_PLAYERS*32-1:0] coll_in,
  input  logic [N_PLAYERS*32-1:0] attack_in,
  input  logic [N_PLAYERS*32-1:0] damage_in,
  output logic [N_PLAYERS*32-1:0] mass_out,
  output logic [N_PLAYERS*32-1:0] start_pos_out,
  output logic [N_PLAYERS*32-1:0] size_out,
  output logic [31:0]             gravity_out,
  output logic [31:0]             wind_out,
  output logic [31:0]             stage_pos_out,
  output logic [31:0]             stage_size_out
);

  logic       cop;
  logic [4:0] blk;
  logic [4:0] idx;
  logic       wr_cop;
  logic       snap;
  logic       freeze;
  logic       unused_addr;
  word_t      frame_cnt;
  word_t      rd_data;

  word_t pos_sh    [N_PLAYERS];
  word_t ctrl_sh   [N_PLAYERS];
  word_t coll_sh   [N_PLAYERS];
  word_t attack_sh [N_PLAYERS];
  word_t damage_sh [N_PLAYERS];
  word_t mass_r    [N_PLAYERS];
  word_t start_r   [N_PLAYERS];
  word_t size_r    [N_PLAYERS];
  word_t gravity_r, wind_r, stage_pos_r, stage_size_r;

  logic [EV_BITS-1:0] ev_flags [N_PLAYERS];
  logic [N_PLAYERS-1:0] ev_clr;

  assign cop          = address[12];
  assign blk          = address[11:7];
  assign idx          = address[6:2];
  assign wr_cop       = wren & cop;
  assign snap         = frame_tick & ~freeze;
  assign dmem_address = address[11:0];
  assign dmem_wren    = wren & ~address[12];
  assign unused_addr  = ^address[1:0];

  // Shadows load together on an unfrozen tick; the counter counts every tick
  always_ff @(posedge clock) begin
    if (!reset) begin
      frame_cnt <= '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
        pos_sh[p]    <= '0;
        ctrl_sh[p]   <= '0;
        coll_sh[p]   <= '0;
        attack_sh[p] <= '0;
        damage_sh[p] <= '0;
      end
    end else begin
      if (frame_tick) frame_cnt <= frame_cnt + 32'd1;
      if (snap) begin
        for (int p = 0; p < N_PLAYERS; p++) begin
          pos_sh[p]    <= pos_in[32*p +: 32];
          ctrl_sh[p]   <= ctrl_in[32*p +: 32];
          coll_sh[p]   <= coll_in[32*p +: 32];
          attack_sh[p] <= attack_in[32*p +: 32];
          damage_sh[p] <= damage_in[32*p +: 32];
        end
      end
    end
  end

  // Writable config; anything not matched here is silently dropped
  always_ff @(posedge clock) begin
    if (!reset) begin
      gravity_r    <= DEF_GRAVITY;
      wind_r       <= DEF_WIND;
      stage_pos_r  <= DEF_STAGE_POS;
      stage_size_r <= DEF_STAGE_SIZE;
      freeze       <= 1'b0;
      for (int p = 0; p < N_PLAYERS; p++) begin
        mass_r[p]  <= DEF_MASS;
        start_r[p] <= start_pos_default(START_X_BASE, START_X_STEP, START_Y, p);
        size_r[p]  <= '0;
      end
    end else if (wr_cop) begin
      if (blk == BLK_PCFG) begin
        for (int p = 0; p < N_PLAYERS; p++) begin
          if (idx[4:2] == 3'(p)) begin
            case (idx[1:0])
              FLD_MASS:  mass_r[p]  <= data_in;
              FLD_START: start_r[p] <= data_in;
              FLD_SIZE:  size_r[p]  <= data_in;
              default: ;
            endcase
          end
        end
      end else if (blk == BLK_GCFG) begin
        case (idx)
          GI_GRAVITY:    gravity_r    <= data_in;
          GI_WIND:       wind_r       <= data_in;
          GI_STAGE_POS:  stage_pos_r  <= data_in;
          GI_STAGE_SIZE: stage_size_r <= data_in;
          GI_CONTROL:    freeze       <= data_in[0];
          default: ;
        endcase
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_PLAYERS; g++) begin : g_player
      assign mass_out[32*g +: 32]      = mass_r[g];
      assign start_pos_out[32*g +: 32] = start_r[g];
      assign size_out[32*g +: 32]      = size_r[g];
      assign ev_clr[g] = rden & cop & (blk == BLK_EVENT) & (idx == 5'(g));

      mmio_event_latch u_event (
        .clock    (clock),
        .reset    (reset),
        .snap     (snap),
        .clr      (ev_clr[g]),
        .dmg_new  (damage_in[32*g +: 32]),
        .dmg_old  (damage_sh[g]),
        .coll_new (coll_in[32*g +: 32]),
        .coll_old (coll_sh[g]),
        .atk_new  (attack_in[32*g]),
        .atk_old  (attack_sh[g][0]),
        .flags    (ev_flags[g])
      );
    end
  endgenerate

  assign gravity_out    = gravity_r;
  assign wind_out       = wind_r;
  assign stage_pos_out  = stage_pos_r;
  assign stage_size_out = stage_size_r;

  // Read mux works from current register values, so a same-edge write
  // is not visible to the read
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (idx == 5'(p)) begin
        case (blk)
          BLK_POS:    rd_data = pos_sh[p];
          BLK_CTRL:   rd_data = ctrl_sh[p];
          BLK_COLL:   rd_data = coll_sh[p];
          BLK_ATTACK: rd_data = attack_sh[p];
          BLK_DAMAGE: rd_data = damage_sh[p];
          BLK_EVENT:  rd_data = {{(32-EV_BITS){1'b0}}, ev_flags[p]};
          default: ;
        endcase
      end
      if (blk == BLK_PCFG && idx[4:2] == 3'(p)) begin
        case (idx[1:0])
          FLD_MASS:  rd_data = mass_r[p];
          FLD_START: rd_data = start_r[p];
          FLD_SIZE:  rd_data = size_r[p];
          default: ;
        endcase
      end
    end
    if (blk == BLK_GCFG) begin
      case (idx)
        GI_GRAVITY:    rd_data = gravity_r;
        GI_WIND:       rd_data = wind_r;
        GI_STAGE_POS:  rd_data = stage_pos_r;
        GI_STAGE_SIZE: rd_data = stage_size_r;
        GI_CONTROL:    rd_data = {31'b0, freeze};
        default: ;
      endcase
    end
    if (blk == BLK_FRAME && idx == 5'd0) rd_data = frame_cnt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rden;
      if (rden) data_out <= cop ? rd_data : dmem_q;
    end
  end

endmodule
